muldiv_unit: RTL

- Iterative RV32M multiply/divide execution unit between register-file read and writeback.
- Consumes the two source operands read from the register file; produces a result plus destination index and write strobe that drive the register file write port.
- One operation in flight at a time; the pipeline stalls on busy.

---
 rtl/muldiv_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Define MULDIV_FAST_MUL_EN to compute multiplies with a single-cycle combinational product.
module muldiv_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned ITERS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            write_enable
);
    localparam int unsigned CW = $clog2(ITERS) + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [2:0]        op;
    logic              neg_main;
    logic              neg_rem;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_next;

    logic              is_mul_in;
    logic              sign_a;
    logic              sign_b;
    logic              neg_in;
    logic [XLEN-1:0]   a_abs;
    logic [XLEN-1:0]   b_abs;
    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     trial;

    always_comb begin
        is_mul_in = ~funct3[2];
        sign_a = rs1_data[XLEN-1] & (funct3 != 3'd3) & (funct3 != 3'd5) & (funct3 != 3'd7);
        sign_b = rs2_data[XLEN-1] & ((funct3 == 3'd0) | (funct3 == 3'd1) |
                                     (funct3 == 3'd4) | (funct3 == 3'd6));
        // A zero divisor must not flip the all-ones quotient; a zero product is unaffected.
        neg_in = (sign_a ^ sign_b) & (|rs2_data);
        a_abs  = sign_a ? -rs1_data : rs1_data;
        b_abs  = sign_b ? -rs2_data : rs2_data;
    end

    // acc holds {hi, multiplier} when multiplying and {remainder, dividend/quotient} when dividing.
    always_comb begin
        add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        shifted = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        trial   = shifted - {1'b0, opnd};
        if (state == MUL)
            acc_next = {add_sum, acc[XLEN-1:1]};
        else if (!trial[XLEN])
            acc_next = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            acc_next = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] prod_full;
    always_comb prod_full = (2*XLEN)'(a_abs) * (2*XLEN)'(b_abs);
`endif

    function automatic logic [XLEN-1:0] finalize(input logic [2:0] f, input logic [2*XLEN-1:0] v,
                                                 input logic nm, input logic nr);
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   q;
        logic [XLEN-1:0]   r;
        logic [XLEN-1:0]   res;
        p = nm ? -v : v;
        q = nm ? -v[XLEN-1:0] : v[XLEN-1:0];
        r = nr ? -v[2*XLEN-1:XLEN] : v[2*XLEN-1:XLEN];
        if (!f[2])
            res = (f == 3'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
        else
            res = f[1] ? r : q;
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            write_enable <= 1'b0;
            result       <= '0;
            rd_out       <= '0;
            cnt          <= '0;
            op           <= '0;
            neg_main     <= 1'b0;
            neg_rem      <= 1'b0;
            opnd         <= '0;
            acc          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op       <= funct3;
                        rd_out   <= rd_in;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        neg_main <= neg_in;
                        neg_rem  <= sign_a;
                        if (is_mul_in) begin
                            opnd <= a_abs;
                            acc  <= {{XLEN{1'b0}}, b_abs};
`ifdef MULDIV_FAST_MUL_EN
                            result       <= finalize(funct3, prod_full, neg_in, sign_a);
                            done         <= 1'b1;
                            write_enable <= |rd_in;
                            state        <= DONE;
`else
                            state <= MUL;
`endif
                        end else begin
                            opnd  <= b_abs;
                            acc   <= {{XLEN{1'b0}}, a_abs};
                            state <= DIV;
                        end
                    end
                end
                MUL, DIV: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(ITERS - 1)) begin
                        result       <= finalize(op, acc_next, neg_main, neg_rem);
                        done         <= 1'b1;
                        write_enable <= |rd_out;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    done         <= 1'b0;
                    write_enable <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
